// File: rtl/axi_stream_strip_header_if.sv
// rtl/axi_stream_strip_header_if.sv - stream bundle for the header stripper: input, payload and header channels
interface axi_stream_strip_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_header;
  logic [DATA_WD-1:0]      data_header;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    ready_header;

  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    output valid_header, data_header, keep_header,
    input  ready_header,
    input  byte_strip_cnt
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    input  valid_header, data_header, keep_header,
    output ready_header,
    output byte_strip_cnt
  );
endinterface

// File: rtl/axi_stream_strip_header.sv
// rtl/axi_stream_strip_header.sv - strips a 1..DATA_BYTE_WD byte header off a packet stream, re-aligning the payload
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                      clk,
  input logic                      rst_n,
  axi_stream_strip_header_if.slave bus
);
  localparam int TW = $clog2(2 * DATA_BYTE_WD);
  localparam logic [TW-1:0] NB = TW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [TW-1:0]           rcnt_q, rcnt_d;
  logic                    sent_q, sent_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    valid_header_q, valid_header_d;
  logic [DATA_WD-1:0]      data_header_q, data_header_d;
  logic [DATA_BYTE_WD-1:0] keep_header_q, keep_header_d;

  logic [BYTE_CNT_WD-1:0]  strip_cnt;
  logic [TW-1:0]           l_cnt, h_cnt, t_sum, first_r;
  logic [DATA_WD-1:0]      byte_mask, din;
  logic [2*DATA_WD-1:0]    wide;
  logic                    out_free, hdr_free, ready_in_c, in_fire;

  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [TW-1:0] n);
    return ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  always_comb begin
    l_cnt     = '0;
    byte_mask = '0;
    for (int j = 0; j < DATA_BYTE_WD; j++) begin
      byte_mask[8*j +: 8] = {8{bus.keep_in[j]}};
      l_cnt               = l_cnt + TW'(bus.keep_in[j]);
    end
  end

  assign strip_cnt = bus.byte_strip_cnt;
  assign din       = bus.data_in & byte_mask;
  assign h_cnt     = TW'(strip_cnt) + TW'(1);
  assign first_r   = (l_cnt > h_cnt) ? (l_cnt - h_cnt) : '0;
  assign t_sum     = rcnt_q + l_cnt;
  // Upper half: residue followed by the input bytes; lower half: bytes left over for the next beat.
  assign wide      = {res_q, {DATA_WD{1'b0}}} | ({din, {DATA_WD{1'b0}}} >> (8 * rcnt_q));
  assign out_free  = !valid_out_q || bus.ready_out;
  assign hdr_free  = !valid_header_q || bus.ready_header;
  assign in_fire   = bus.valid_in && ready_in_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire && !bus.last_in) state_d = BODY;
      BODY:    if (in_fire && bus.last_in) state_d = (t_sum > NB) ? FLUSH : IDLE;
      FLUSH:   if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_in_c = 1'b0;
    case (state_q)
      IDLE:    ready_in_c = hdr_free && out_free;
      BODY:    ready_in_c = out_free;
      default: ready_in_c = 1'b0;
    endcase
    ready_in_c = ready_in_c && rst_n;
  end

  always_comb begin
    res_d          = res_q;
    rcnt_d         = rcnt_q;
    sent_d         = sent_q;
    valid_out_d    = valid_out_q && !bus.ready_out;
    data_out_d     = data_out_q;
    keep_out_d     = keep_out_q;
    last_out_d     = last_out_q;
    valid_header_d = valid_header_q && !bus.ready_header;
    data_header_d  = data_header_q;
    keep_header_d  = keep_header_q;
    case (state_q)
      IDLE: if (in_fire) begin
        valid_header_d = 1'b1;
        data_header_d  = din & ~({DATA_WD{1'b1}} >> (8 * h_cnt));
        keep_header_d  = bus.keep_in & keep_of(h_cnt);
        sent_d         = 1'b0;
        if (bus.last_in) begin
          res_d  = '0;
          rcnt_d = '0;
          if (first_r != '0) begin
            valid_out_d = 1'b1;
            data_out_d  = din << (8 * h_cnt);
            keep_out_d  = keep_of(first_r);
            last_out_d  = 1'b1;
          end
        end else begin
          res_d  = din << (8 * h_cnt);
          rcnt_d = first_r;
        end
      end
      BODY: if (in_fire) begin
        if (bus.last_in && t_sum <= NB) begin
          // An empty closing beat still has to deliver last_out once payload has started.
          if (t_sum != '0 || sent_q) begin
            valid_out_d = 1'b1;
            data_out_d  = wide[2*DATA_WD-1:DATA_WD];
            keep_out_d  = keep_of(t_sum);
            last_out_d  = 1'b1;
          end
          res_d  = '0;
          rcnt_d = '0;
        end else if (t_sum >= NB) begin
          valid_out_d = 1'b1;
          data_out_d  = wide[2*DATA_WD-1:DATA_WD];
          keep_out_d  = '1;
          last_out_d  = 1'b0;
          sent_d      = 1'b1;
          res_d       = wide[DATA_WD-1:0];
          rcnt_d      = t_sum - NB;
        end else begin
          res_d  = wide[2*DATA_WD-1:DATA_WD];
          rcnt_d = t_sum;
        end
      end
      FLUSH: if (out_free) begin
        valid_out_d = 1'b1;
        data_out_d  = res_q;
        keep_out_d  = keep_of(rcnt_q);
        last_out_d  = 1'b1;
        res_d       = '0;
        rcnt_d      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q          <= '0;
      rcnt_q         <= '0;
      sent_q         <= 1'b0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      valid_header_q <= 1'b0;
      data_header_q  <= '0;
      keep_header_q  <= '0;
    end else begin
      res_q          <= res_d;
      rcnt_q         <= rcnt_d;
      sent_q         <= sent_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      keep_out_q     <= keep_out_d;
      last_out_q     <= last_out_d;
      valid_header_q <= valid_header_d;
      data_header_q  <= data_header_d;
      keep_header_q  <= keep_header_d;
    end
  end

  assign bus.ready_in     = ready_in_c;
  assign bus.valid_out    = valid_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.keep_out     = keep_out_q;
  assign bus.last_out     = last_out_q;
  assign bus.valid_header = valid_header_q;
  assign bus.data_header  = data_header_q;
  assign bus.keep_header  = keep_header_q;
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb/tb_axi_stream_strip_header.sv - directed and random packets checked against a byte-list reference model
module tb_axi_stream_strip_header;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        mon_en  = 1'b0;
  logic        rand_bp = 1'b0;
  logic        stall_pl = 1'b0;
  logic        stall_hd = 1'b0;
  logic [36:0] hold_pl;
  logic [35:0] hold_hd;
  int          n_cmp = 0;
  int          n_err = 0;
  beat_t       exp_hd[$];
  beat_t       exp_pl[$];

  axi_stream_strip_header_if #(.DATA_WD(32)) bus ();
  axi_stream_strip_header dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_hd(input logic [31:0] d, input logic [3:0] k);
    beat_t b;
    b.d = d; b.k = k; b.l = 1'b0;
    exp_hd.push_back(b);
  endtask

  task automatic push_pl(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    exp_pl.push_back(b);
  endtask

  // Reference: header = first H bytes of the packet, payload = the rest re-packed 4 bytes per beat.
  task automatic model_packet(input int hm1, input bq_t pkt);
    int          h   = hm1 + 1;
    int          len = pkt.size();
    logic [31:0] d;
    logic [3:0]  k;
    d = '0; k = '0;
    for (int i = 0; i < h && i < len; i++) begin
      d[31-8*i -: 8] = pkt[i];
      k[3-i]         = 1'b1;
    end
    push_hd(d, k);
    for (int off = h; off < len; off += 4) begin
      d = '0; k = '0;
      for (int i = 0; i < 4 && off + i < len; i++) begin
        d[31-8*i -: 8] = pkt[off+i];
        k[3-i]         = 1'b1;
      end
      push_pl(d, k, off + 4 >= len);
    end
  endtask

  function automatic logic [35:0] beat_of(input bq_t pkt, input int b);
    logic [31:0] d;
    logic [3:0]  k;
    d = $urandom;
    k = '0;
    for (int i = 0; i < 4; i++)
      if (b * 4 + i < pkt.size()) begin
        d[31-8*i -: 8] = pkt[b*4+i];
        k[3-i]         = 1'b1;
      end
    return {d, k};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l;
    @(negedge clk);
    while (!bus.ready_in && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_handshake_in_time", t < 200, 1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0; bus.last_in = 1'b0;
  endtask

  task automatic send_beats(input bq_t pkt);
    int          nb = (pkt.size() + 3) / 4;
    logic [35:0] dk;
    for (int b = 0; b < nb; b++) begin
      dk = beat_of(pkt, b);
      send_beat(dk[35:4], dk[3:0], b == nb - 1);
      bus.byte_strip_cnt = 2'($urandom);
    end
  endtask

  task automatic send_packet(input int hm1, input bq_t pkt);
    model_packet(hm1, pkt);
    bus.byte_strip_cnt = 2'(hm1);
    send_beats(pkt);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_hd.size() != 0 || exp_pl.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_hd_left", exp_hd.size(), 0);
    chk("drain_pl_left", exp_pl.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_basic();
    bus.byte_strip_cnt = 2'd1;
    push_hd(32'hA1A20000, 4'hC);
    push_pl(32'hA3A4B1B2, 4'hF, 1'b0);
    push_pl(32'hB3B4C1C2, 4'hF, 1'b1);
    send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
    bus.byte_strip_cnt = 2'd3;
    send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
    send_beat(32'hC1C2C3C4, 4'hC, 1'b1);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && rst_n) begin
      if (stall_pl)
        chk("pl_hold", {bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}, {1'b1, hold_pl});
      if (stall_hd)
        chk("hd_hold", {bus.valid_header, bus.data_header, bus.keep_header}, {1'b1, hold_hd});
      if (bus.valid_out && bus.ready_out) begin
        n_cmp++;
        assert (exp_pl.size() != 0) else begin
          n_err++;
          $error("FAIL pl_unexpected observed=%h/%h expected=no beat", bus.data_out, bus.keep_out);
        end
        if (exp_pl.size() != 0) begin
          e = exp_pl.pop_front();
          chk("pl_beat", {bus.data_out, bus.keep_out, bus.last_out}, {e.d, e.k, e.l});
        end
      end
      if (bus.valid_header && bus.ready_header) begin
        n_cmp++;
        assert (exp_hd.size() != 0) else begin
          n_err++;
          $error("FAIL hd_unexpected observed=%h/%h expected=no header", bus.data_header, bus.keep_header);
        end
        if (exp_hd.size() != 0) begin
          e = exp_hd.pop_front();
          chk("hd_beat", {bus.data_header, bus.keep_header}, {e.d, e.k});
        end
      end
      stall_pl = bus.valid_out && !bus.ready_out;
      hold_pl  = {bus.data_out, bus.keep_out, bus.last_out};
      stall_hd = bus.valid_header && !bus.ready_header;
      hold_hd  = {bus.data_header, bus.keep_header};
    end else begin
      stall_pl = 1'b0;
      stall_hd = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) begin
      bus.ready_out    = ($urandom_range(0, 3) != 0);
      bus.ready_header = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         p;
    logic [35:0] dk;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.ready_out = 1'b1; bus.ready_header = 1'b1; bus.byte_strip_cnt = '0;

    repeat (2) @(negedge clk);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_valid_header", bus.valid_header, 0);
    chk("rst_last_out", bus.last_out, 0);
    chk("rst_data_keep", {bus.data_out, bus.keep_out, bus.data_header, bus.keep_header}, 0);
    chk("rst_ready_in", bus.ready_in, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("idle_ready_in", bus.ready_in, 1);
    @(posedge clk);
    #1;

    run_basic();

    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    send_packet(0, p);
    chk("flush_ready_in", bus.ready_in, 0);
    @(posedge clk);
    #1;
    chk("after_flush_ready_in", bus.ready_in, 1);

    bus.byte_strip_cnt = 2'd3;
    push_hd(32'hDEADBEEF, 4'hF);
    push_pl(32'h01000000, 4'h8, 1'b1);
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    send_beat(32'h01020304, 4'h8, 1'b1);

    bus.byte_strip_cnt = 2'd3;
    push_hd(32'hCAFEF00D, 4'hF);
    send_beat(32'hCAFEF00D, 4'hF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("hdr_only_no_payload", bus.valid_out, 0);
    end
    chk("hdr_only_idle_ready", bus.ready_in, 1);
    @(posedge clk);
    #1;

    bus.byte_strip_cnt = 2'd1;
    push_hd(32'h01020000, 4'hC);
    push_pl(32'h03040000, 4'hC, 1'b1);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h99887766, 4'h0, 1'b1);

    bus.byte_strip_cnt = 2'd1;
    push_hd(32'h10200000, 4'hC);
    push_pl(32'h30405060, 4'hF, 1'b0);
    push_pl(32'h70800000, 4'hC, 1'b1);
    send_beat(32'h10203040, 4'hF, 1'b0);
    send_beat(32'h5A5A5A5A, 4'h0, 1'b0);
    send_beat(32'h50607080, 4'hF, 1'b1);
    drain();

    p.delete();
    for (int i = 0; i < 16; i++) p.push_back(8'($urandom));
    bus.ready_out = 1'b0;
    model_packet(1, p);
    bus.byte_strip_cnt = 2'd1;
    dk = beat_of(p, 0); send_beat(dk[35:4], dk[3:0], 1'b0);
    dk = beat_of(p, 1); send_beat(dk[35:4], dk[3:0], 1'b0);
    dk = beat_of(p, 2);
    bus.valid_in = 1'b1; bus.data_in = dk[35:4]; bus.keep_in = dk[3:0]; bus.last_in = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_in", bus.ready_in, 0);
    end
    @(posedge clk);
    #1;
    bus.ready_out = 1'b1;
    send_beat(dk[35:4], dk[3:0], 1'b0);
    dk = beat_of(p, 3); send_beat(dk[35:4], dk[3:0], 1'b1);

    bus.ready_header = 1'b0;
    p.delete();
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    send_packet(2, p);
    p.delete();
    for (int i = 0; i < 6; i++) p.push_back(8'($urandom));
    model_packet(0, p);
    bus.byte_strip_cnt = 2'd0;
    dk = beat_of(p, 0);
    bus.valid_in = 1'b1; bus.data_in = dk[35:4]; bus.keep_in = dk[3:0]; bus.last_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hdr_block_ready_in", bus.ready_in, 0);
    end
    @(posedge clk);
    #1;
    bus.ready_header = 1'b1;
    send_beats(p);
    drain();

    mon_en = 1'b0;
    bus.ready_out = 1'b0; bus.ready_header = 1'b0;
    bus.byte_strip_cnt = 2'd1;
    send_beat(32'h0A0B0C0D, 4'hF, 1'b0);
    send_beat(32'h1A1B1C1D, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", bus.valid_out, 0);
    chk("midrst_valid_header", bus.valid_header, 0);
    chk("midrst_last_out", bus.last_out, 0);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_keep_out", bus.keep_out, 0);
    chk("midrst_header", {bus.data_header, bus.keep_header}, 0);
    chk("midrst_ready_in", bus.ready_in, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.ready_out = 1'b1; bus.ready_header = 1'b1;
    exp_hd.delete(); exp_pl.delete();
    mon_en = 1'b1;
    run_basic();
    drain();

    rand_bp = 1'b1;
    repeat (150) begin
      p.delete();
      for (int i = 0; i < $urandom_range(1, 16); i++) p.push_back(8'($urandom));
      send_packet($urandom_range(0, 3), p);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.ready_out = 1'b1; bus.ready_header = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
